// File: rtl/hdmi_timing_gen.sv
`default_nettype none
// hdmi_timing_gen -- raster timing for a TMDS transmitter; new modes switch only on frame boundaries.
// Rev 1.0
module hdmi_timing_gen #(
  parameter int CNT_W  = 11,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_hfp,
  input  logic [CNT_W-1:0] cfg_hs,
  input  logic [CNT_W-1:0] cfg_hbp,
  input  logic [CNT_W-1:0] cfg_hpix,
  input  logic [CNT_W-1:0] cfg_vfp,
  input  logic [CNT_W-1:0] cfg_vs,
  input  logic [CNT_W-1:0] cfg_vbp,
  input  logic [CNT_W-1:0] cfg_vpix,
  output logic             cfg_err,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             de,
  output logic [1:0]       vh,
  output logic             line_start,
  output logic             frame_start,
  output logic             mode_applied
);

  localparam int               W2      = CNT_W + 2;
  localparam logic [W2-1:0]    ONE_W   = W2'(1);
  localparam logic [W2-1:0]    MAX_TOT = ONE_W << CNT_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [1:0]       VH_IDLE = {~VS_POL, ~HS_POL};

  localparam logic [CNT_W-1:0] DEF_HFP  = CNT_W'(20);
  localparam logic [CNT_W-1:0] DEF_HS   = CNT_W'(60);
  localparam logic [CNT_W-1:0] DEF_HBP  = CNT_W'(110);
  localparam logic [CNT_W-1:0] DEF_HPIX = CNT_W'(1024);
  localparam logic [CNT_W-1:0] DEF_VFP  = CNT_W'(30);
  localparam logic [CNT_W-1:0] DEF_VS   = CNT_W'(80);
  localparam logic [CNT_W-1:0] DEF_VBP  = CNT_W'(110);
  localparam logic [CNT_W-1:0] DEF_VPIX = CNT_W'(600);

  function automatic logic [W2-1:0] ext(input logic [CNT_W-1:0] v);
    return {2'b00, v};
  endfunction

  logic [CNT_W-1:0] hcnt, vcnt;
  logic [CNT_W-1:0] a_hfp, a_hs, a_hbp, a_hpix, a_vfp, a_vs, a_vbp, a_vpix;
  logic [CNT_W-1:0] p_hfp, p_hs, p_hbp, p_hpix, p_vfp, p_vs, p_vbp, p_vpix;
  logic             pend;
  logic             apply_d;

  logic [W2-1:0] h_sync_beg, h_sync_end, h_tot;
  logic [W2-1:0] v_sync_beg, v_sync_end, v_tot;
  logic [W2-1:0] cfg_h_tot, cfg_v_tot;
  logic          h_last, v_last, hs_on, vs_on, de_next, cfg_ok, load_pending;

  // Boundaries are summed at CNT_W+2 bits so an oversize offered mode cannot alias.
  assign h_sync_beg = ext(a_hpix) + ext(a_hfp);
  assign h_sync_end = h_sync_beg + ext(a_hs);
  assign h_tot      = h_sync_end + ext(a_hbp);
  assign v_sync_beg = ext(a_vpix) + ext(a_vfp);
  assign v_sync_end = v_sync_beg + ext(a_vs);
  assign v_tot      = v_sync_end + ext(a_vbp);

  assign h_last  = (ext(hcnt) == (h_tot - ONE_W));
  assign v_last  = (ext(vcnt) == (v_tot - ONE_W));
  assign hs_on   = (ext(hcnt) >= h_sync_beg) && (ext(hcnt) < h_sync_end);
  assign vs_on   = (ext(vcnt) >= v_sync_beg) && (ext(vcnt) < v_sync_end);
  assign de_next = (hcnt < a_hpix) && (vcnt < a_vpix);

  assign cfg_h_tot = ext(cfg_hpix) + ext(cfg_hfp) + ext(cfg_hs) + ext(cfg_hbp);
  assign cfg_v_tot = ext(cfg_vpix) + ext(cfg_vfp) + ext(cfg_vs) + ext(cfg_vbp);
  assign cfg_ok    = (cfg_hpix != '0) && (cfg_hs != '0) && (cfg_vpix != '0) && (cfg_vs != '0) &&
                     (cfg_h_tot <= MAX_TOT) && (cfg_v_tot <= MAX_TOT);

  // Idle generator swaps immediately; a running one only at the last pixel of a frame.
  assign load_pending = pend && (!en || (h_last && v_last));

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      hcnt         <= '0;
      vcnt         <= '0;
      a_hfp        <= DEF_HFP;
      a_hs         <= DEF_HS;
      a_hbp        <= DEF_HBP;
      a_hpix       <= DEF_HPIX;
      a_vfp        <= DEF_VFP;
      a_vs         <= DEF_VS;
      a_vbp        <= DEF_VBP;
      a_vpix       <= DEF_VPIX;
      p_hfp        <= '0;
      p_hs         <= '0;
      p_hbp        <= '0;
      p_hpix       <= '0;
      p_vfp        <= '0;
      p_vs         <= '0;
      p_vbp        <= '0;
      p_vpix       <= '0;
      pend         <= 1'b0;
      apply_d      <= 1'b0;
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
      x            <= '0;
      y            <= '0;
      de           <= 1'b0;
      vh           <= VH_IDLE;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      mode_applied <= 1'b0;
    end else begin
      cfg_err      <= 1'b0;
      mode_applied <= 1'b0;
      apply_d      <= 1'b0;

      if (load_pending) begin
        a_hfp  <= p_hfp;
        a_hs   <= p_hs;
        a_hbp  <= p_hbp;
        a_hpix <= p_hpix;
        a_vfp  <= p_vfp;
        a_vs   <= p_vs;
        a_vbp  <= p_vbp;
        a_vpix <= p_vpix;
        pend   <= 1'b0;
      end

      if (en) begin
        x           <= hcnt;
        y           <= vcnt;
        de          <= de_next;
        vh          <= {vs_on, hs_on} ~^ {VS_POL, HS_POL};
        line_start  <= (hcnt == '0);
        frame_start <= (hcnt == '0) && (vcnt == '0);
        if (h_last) begin
          hcnt <= '0;
          vcnt <= v_last ? '0 : vcnt + CNT_ONE;
        end else begin
          hcnt <= hcnt + CNT_ONE;
        end
        // Announce the swap alongside the frame_start of the first frame using it.
        apply_d <= load_pending;
      end else begin
        x           <= '0;
        y           <= '0;
        de          <= 1'b0;
        vh          <= VH_IDLE;
        line_start  <= 1'b0;
        frame_start <= 1'b0;
        hcnt        <= '0;
        vcnt        <= '0;
        if (load_pending) begin
          mode_applied <= 1'b1;
          cfg_ready    <= 1'b1;
        end
      end

      if (apply_d) begin
        mode_applied <= 1'b1;
        cfg_ready    <= 1'b1;
      end

      if (cfg_valid && cfg_ready) begin
        if (cfg_ok) begin
          p_hfp     <= cfg_hfp;
          p_hs      <= cfg_hs;
          p_hbp     <= cfg_hbp;
          p_hpix    <= cfg_hpix;
          p_vfp     <= cfg_vfp;
          p_vs      <= cfg_vs;
          p_vbp     <= cfg_vbp;
          p_vpix    <= cfg_vpix;
          pend      <= 1'b1;
          cfg_ready <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdmi_timing_gen.sv
`default_nettype none
// tb_hdmi_timing_gen -- scoreboard bench for hdmi_timing_gen (active-high and active-low sync instances).
// Rev 1.0
module tb_hdmi_timing_gen;

  localparam int CW = 11;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic          rst, en, cfg_valid;
  logic [CW-1:0] cfg_hfp, cfg_hs, cfg_hbp, cfg_hpix, cfg_vfp, cfg_vs, cfg_vbp, cfg_vpix;

  logic          a_cfg_ready, a_cfg_err, a_de, a_line_start, a_frame_start, a_mode_applied;
  logic [CW-1:0] a_x, a_y;
  logic [1:0]    a_vh;
  logic          b_cfg_ready, b_cfg_err, b_de, b_line_start, b_frame_start, b_mode_applied;
  logic [CW-1:0] b_x, b_y;
  logic [1:0]    b_vh;

  hdmi_timing_gen #(.CNT_W(CW), .HS_POL(1'b1), .VS_POL(1'b1)) dut (
    .clk_pix(clk_pix), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(a_cfg_ready),
    .cfg_hfp(cfg_hfp), .cfg_hs(cfg_hs), .cfg_hbp(cfg_hbp), .cfg_hpix(cfg_hpix),
    .cfg_vfp(cfg_vfp), .cfg_vs(cfg_vs), .cfg_vbp(cfg_vbp), .cfg_vpix(cfg_vpix),
    .cfg_err(a_cfg_err), .x(a_x), .y(a_y), .de(a_de), .vh(a_vh),
    .line_start(a_line_start), .frame_start(a_frame_start), .mode_applied(a_mode_applied)
  );

  hdmi_timing_gen #(.CNT_W(CW), .HS_POL(1'b0), .VS_POL(1'b0)) dut_n (
    .clk_pix(clk_pix), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(b_cfg_ready),
    .cfg_hfp(cfg_hfp), .cfg_hs(cfg_hs), .cfg_hbp(cfg_hbp), .cfg_hpix(cfg_hpix),
    .cfg_vfp(cfg_vfp), .cfg_vs(cfg_vs), .cfg_vbp(cfg_vbp), .cfg_vpix(cfg_vpix),
    .cfg_err(b_cfg_err), .x(b_x), .y(b_y), .de(b_de), .vh(b_vh),
    .line_start(b_line_start), .frame_start(b_frame_start), .mode_applied(b_mode_applied)
  );

  typedef struct packed {
    logic          rdy;
    logic          err;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          de;
    logic [1:0]    vh;
    logic          ls;
    logic          fs;
    logic          ma;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference model: counter position, active/pending modes (hfp,hs,hbp,hpix,vfp,vs,vbp,vpix).
  int mh, mv;
  int cur[8];
  int pen[8];
  int dflt[8] = '{20, 60, 110, 1024, 30, 80, 110, 600};
  bit m_pend, m_appl, m_ready;

  int de_cnt, hs_cnt, hs_first, vs_cnt, vs_first, fs_cnt, ls_cnt, ma_cnt, last_fs, fs_gap;

  task automatic reset_meas();
    de_cnt = 0; hs_cnt = 0; hs_first = -1; vs_cnt = 0; vs_first = -1;
    fs_cnt = 0; ls_cnt = 0; ma_cnt = 0; last_fs = -1; fs_gap = -1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    out_t e, en_exp, ga, gb;
    int   c[8];
    int   ht, vt, cht, cvt, nxt_appl;
    bit   ok, hs_on, vs_on, rdy;
    c = '{int'(cfg_hfp), int'(cfg_hs), int'(cfg_hbp), int'(cfg_hpix),
          int'(cfg_vfp), int'(cfg_vs), int'(cfg_vbp), int'(cfg_vpix)};
    cht = c[0] + c[1] + c[2] + c[3];
    cvt = c[4] + c[5] + c[6] + c[7];
    ok  = (c[3] != 0) && (c[1] != 0) && (c[7] != 0) && (c[5] != 0) && (cht <= 2048) && (cvt <= 2048);
    e = '0;
    if (rst) begin
      e.rdy = 1'b1;
      mh = 0; mv = 0; cur = dflt; m_pend = 0; m_appl = 0; m_ready = 1;
    end else begin
      ht = cur[0] + cur[1] + cur[2] + cur[3];
      vt = cur[4] + cur[5] + cur[6] + cur[7];
      if (en) begin
        hs_on = (mh >= cur[3] + cur[0]) && (mh < cur[3] + cur[0] + cur[1]);
        vs_on = (mv >= cur[7] + cur[4]) && (mv < cur[7] + cur[4] + cur[5]);
        e.x  = CW'(mh);
        e.y  = CW'(mv);
        e.de = (mh < cur[3]) && (mv < cur[7]);
        e.vh = {vs_on, hs_on};
        e.ls = (mh == 0);
        e.fs = (mh == 0) && (mv == 0);
      end
      e.ma  = m_appl || (!en && m_pend);
      e.err = cfg_valid && m_ready && !ok;
      rdy   = m_ready || e.ma;
      nxt_appl = 0;
      if (en) begin
        if (mh == ht - 1) begin
          mh = 0;
          if (mv == vt - 1) begin
            mv = 0;
            if (m_pend) begin cur = pen; m_pend = 0; nxt_appl = 1; end
          end else mv++;
        end else mh++;
      end else begin
        mh = 0; mv = 0;
        if (m_pend) begin cur = pen; m_pend = 0; end
      end
      m_appl = nxt_appl[0];
      if (cfg_valid && m_ready && ok) begin pen = c; m_pend = 1; rdy = 0; end
      m_ready = rdy;
      e.rdy = rdy;
    end
    exp_q.push_back(e);

    @(posedge clk_pix);
    #1;
    e  = exp_q.pop_front();
    ga = {a_cfg_ready, a_cfg_err, a_x, a_y, a_de, a_vh, a_line_start, a_frame_start, a_mode_applied};
    gb = {b_cfg_ready, b_cfg_err, b_x, b_y, b_de, b_vh, b_line_start, b_frame_start, b_mode_applied};
    checks++;
    assert (ga === e) else begin
      failures++;
      $error("FAIL out_pol1 cyc=%0d obs=%h exp=%h", cyc, ga, e);
    end
    en_exp = e;
    en_exp.vh = ~e.vh;
    checks++;
    assert (gb === en_exp) else begin
      failures++;
      $error("FAIL out_pol0 cyc=%0d obs=%h exp=%h", cyc, gb, en_exp);
    end

    if (a_de) de_cnt++;
    if (a_vh[0]) begin if (hs_cnt == 0) hs_first = int'(a_x); hs_cnt++; end
    if (a_vh[1]) begin if (vs_cnt == 0) vs_first = int'(a_y); vs_cnt++; end
    if (a_line_start) ls_cnt++;
    if (a_mode_applied) ma_cnt++;
    if (a_frame_start) begin
      if (last_fs >= 0) fs_gap = cyc - last_fs;
      last_fs = cyc;
      fs_cnt++;
    end
    cyc++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cfg(input int hfp, input int hs, input int hbp, input int hpix,
                         input int vfp, input int vs, input int vbp, input int vpix);
    cfg_hfp = CW'(hfp); cfg_hs = CW'(hs); cfg_hbp = CW'(hbp); cfg_hpix = CW'(hpix);
    cfg_vfp = CW'(vfp); cfg_vs = CW'(vs); cfg_vbp = CW'(vbp); cfg_vpix = CW'(vpix);
  endtask

  task automatic scramble_cfg();
    set_cfg($urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
            $urandom_range(0, 2047), $urandom_range(0, 2047), $urandom_range(0, 2047),
            $urandom_range(0, 2047), $urandom_range(0, 2047));
  endtask

  // Offer one set with en=1 so it goes pending, then drop en for a cycle to swap it in at once.
  task automatic apply_now(input int hfp, input int hs, input int hbp, input int hpix,
                           input int vfp, input int vs, input int vbp, input int vpix);
    en = 1'b1;
    set_cfg(hfp, hs, hbp, hpix, vfp, vs, vbp, vpix);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    scramble_cfg();
    chk("pend_ready_low", a_cfg_ready, 0);
    en = 1'b0;
    tick();
    chk("idle_apply_ma", a_mode_applied, 1);
    chk("idle_apply_ready", a_cfg_ready, 1);
    en = 1'b1;
  endtask

  // Tick until the model's counter sits at (h,v), i.e. the next edge samples that position.
  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(mh == h && mv == v) && n < 5000) begin tick(); n++; end
    chk("run_to_bound", int'(mh == h && mv == v), 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    reset_meas();

    ticks(2);
    chk("rst_ready", a_cfg_ready, 1);
    chk("rst_vh_pol1", a_vh, 0);
    chk("rst_vh_pol0", b_vh, 3);
    chk("rst_de", a_de, 0);

    rst = 1'b0;
    ticks(2);
    chk("idle_vh_pol0", b_vh, 3);

    // Default mode, first two lines.
    en = 1'b1;
    reset_meas();
    tick();
    chk("start_fs", a_frame_start, 1);
    chk("start_ls", a_line_start, 1);
    chk("start_de", a_de, 1);
    ticks(1213);
    chk("def_de_line", de_cnt, 1024);
    chk("def_hs_first", hs_first, 1044);
    chk("def_hs_len", hs_cnt, 60);
    ticks(1214);
    chk("def_ls_cnt", ls_cnt, 2);
    chk("def_de_2lines", de_cnt, 2048);

    // Rejected sets: zero hpix, then oversize line (2040+3+4+3 = 2050).
    set_cfg(20, 60, 110, 0, 30, 80, 110, 600);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("rej_zero_err", a_cfg_err, 1);
    chk("rej_zero_ready", a_cfg_ready, 1);
    tick();
    chk("rej_err_pulse", a_cfg_err, 0);
    set_cfg(3, 4, 3, 2040, 1, 1, 1, 2);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("rej_big_err", a_cfg_err, 1);
    chk("rej_big_ready", a_cfg_ready, 1);
    ticks(3);

    // Largest legal line, HT = 2048 exactly.
    apply_now(3, 4, 1, 2040, 1, 1, 1, 2);
    reset_meas();
    ticks(2100);
    chk("max_hs_first", hs_first, 2043);
    chk("max_hs_len", hs_cnt, 4);
    chk("max_ls_cnt", ls_cnt, 2);

    // Mode B via idle swap, then mode A (HT=8, VT=5) offered mid-frame.
    apply_now(2, 3, 1, 6, 1, 2, 1, 3);
    ticks(30);
    set_cfg(1, 2, 1, 4, 1, 1, 1, 2);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    scramble_cfg();
    reset_meas();
    ticks(100);
    chk("a_ma_once", ma_cnt, 1);
    run_to(0, 0);
    reset_meas();
    ticks(120);
    chk("a_fs_gap", fs_gap, 40);
    chk("a_fs_cnt", fs_cnt, 3);
    chk("a_hs_first", hs_first, 5);
    chk("a_hs_cnt", hs_cnt, 30);
    chk("a_vs_first", vs_first, 3);
    chk("a_vs_cnt", vs_cnt, 24);
    chk("a_de_cnt", de_cnt, 24);

    // Offer mode C (HT=7, VT=5) in the exact wrap cycle.
    run_to(7, 4);
    set_cfg(2, 1, 1, 3, 1, 1, 1, 2);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    scramble_cfg();
    reset_meas();
    ticks(40);
    chk("wrap_no_ma", ma_cnt, 0);
    chk("wrap_fs_cnt", fs_cnt, 1);
    tick();
    chk("wrap_next_ma", a_mode_applied, 1);
    chk("wrap_next_fs", a_frame_start, 1);
    run_to(0, 0);
    reset_meas();
    ticks(71);
    chk("c_fs_gap", fs_gap, 35);
    chk("c_fs_cnt", fs_cnt, 3);

    // Reset mid-frame with a set pending.
    ticks(13);
    set_cfg(1, 1, 1, 1, 1, 1, 1, 1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("pre_rst_pend", a_cfg_ready, 0);
    ticks(5);
    rst = 1'b1;
    tick();
    chk("rst_mid_ready", a_cfg_ready, 1);
    rst = 1'b0;
    reset_meas();
    tick();
    chk("restart_fs", a_frame_start, 1);
    ticks(1214);
    chk("restart_hs_first", hs_first, 1044);
    chk("restart_ls_cnt", ls_cnt, 2);
    chk("restart_no_ma", ma_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
